// File: rtl/div_float_seq.sv
// ============================================================================
// Module      : div_float_seq
// Description : Valid/ready sequencer around an iterative float divider with
//               a small output FIFO. Optional RUN-state timeout is enabled by
//               defining DIV_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_float_seq #(
  parameter int FLOAT_WIDTH    = 64,
  parameter int OUT_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_op1,
  input  logic [FLOAT_WIDTH-1:0] in_op2,
  output logic                   div_start,
  output logic [FLOAT_WIDTH-1:0] div_op1,
  output logic [FLOAT_WIDTH-1:0] div_op2,
  input  logic [FLOAT_WIDTH-1:0] div_out,
  input  logic [4:0]             div_flags,
  input  logic                   div_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_result,
  output logic [5:0]             out_flags,
  output logic                   busy
);

  localparam int c_PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(OUT_DEPTH);
  localparam logic [FLOAT_WIDTH-1:0] c_QNAN = (FLOAT_WIDTH == 64) ?
      FLOAT_WIDTH'(64'hFFF8_0000_0000_0000) : FLOAT_WIDTH'(32'hFFC0_0000);
  localparam logic [5:0] c_TIMEOUT_FLAGS = 6'b110000;

  if (!(FLOAT_WIDTH == 32 || FLOAT_WIDTH == 64)) begin : g_bad_width
    $error("div_float_seq: FLOAT_WIDTH must be 32 or 64");
  end
  if ((OUT_DEPTH < 2) || ((OUT_DEPTH & (OUT_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("div_float_seq: OUT_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("div_float_seq: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_first;
  logic                   r_div_start;
  logic                   r_busy;
  logic [FLOAT_WIDTH-1:0] r_div_op1;
  logic [FLOAT_WIDTH-1:0] r_div_op2;

  logic [c_CW-1:0]        r_count;
  logic [c_PW-1:0]        r_wptr;
  logic [c_PW-1:0]        r_rptr;
  logic [FLOAT_WIDTH-1:0] r_mem_res [OUT_DEPTH];
  logic [5:0]             r_mem_flg [OUT_DEPTH];

  logic                   w_accept;
  logic                   w_done_ok;
  logic                   w_timeout;
  logic                   w_push;
  logic                   w_pop;
  logic [FLOAT_WIDTH-1:0] w_push_res;
  logic [5:0]             w_push_flg;

  // Slot is reserved at accept: the registered count gates acceptance.
  assign in_ready  = rst_n && (r_state == S_IDLE) && (r_count < c_DEPTH);
  assign w_accept  = in_valid && in_ready;
  // The first RUN cycle may still show a done left over from before start fell.
  assign w_done_ok = (r_state == S_RUN) && !r_first && div_done;

`ifdef DIV_SEQ_TIMEOUT_EN
  localparam int c_TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_TW     = (c_TW_RAW < 8) ? 8 : ((c_TW_RAW > 16) ? 16 : c_TW_RAW);

  logic [c_TW-1:0] r_tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_accept) begin
      r_tcnt <= '0;
    end else if (r_state == S_RUN) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && !w_done_ok &&
                     (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_push     = w_done_ok || w_timeout;
  assign w_push_res = w_done_ok ? div_out : c_QNAN;
  assign w_push_flg = w_done_ok ? {1'b0, div_flags} : c_TIMEOUT_FLAGS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b0;
      r_div_start <= 1'b1;
      r_busy      <= 1'b0;
      r_div_op1   <= '0;
      r_div_op2   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_RUN;
            r_first     <= 1'b1;
            r_div_start <= 1'b0;
            r_busy      <= 1'b1;
            r_div_op1   <= in_op1;
            r_div_op2   <= in_op2;
          end
        end
        S_RUN: begin
          r_first <= 1'b0;
          if (w_push) begin
            r_state     <= S_IDLE;
            r_div_start <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_div_start <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign div_start = r_div_start;
  assign div_op1   = r_div_op1;
  assign div_op2   = r_div_op2;
  assign busy      = r_busy;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem_res[i] <= '0;
        r_mem_flg[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_res[r_wptr] <= w_push_res;
        r_mem_flg[r_wptr] <= w_push_flg;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_result = r_mem_res[r_rptr];
  assign out_flags  = r_mem_flg[r_rptr];

endmodule

`default_nettype wire

// File: tb/tb_div_float_seq.sv
// Directed bench for div_float_seq at FLOAT_WIDTH=32 with a behavioural divider model.
`default_nettype none

module tb_div_float_seq;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_op1 = '0;
  logic [FW-1:0] in_op2 = '0;
  logic          div_start;
  logic [FW-1:0] div_op1;
  logic [FW-1:0] div_op2;
  logic [FW-1:0] div_out;
  logic [4:0]    div_flags;
  logic          div_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] out_result;
  logic [5:0]    out_flags;
  logic          busy;

  int n_err = 0;
  int n_chk = 0;

  // Divider model: done rises m_lat edges after start falls.
  int       m_cnt = 0;
  int       m_lat = 27;
  bit       m_stale = 1'b0;
  bit       m_never = 1'b0;
  logic [4:0] m_flg = 5'b0;

  always #5 clk = ~clk;

  div_float_seq #(
    .FLOAT_WIDTH   (FW),
    .OUT_DEPTH     (2),
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .div_start (div_start),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .div_out   (div_out),
    .div_flags (div_flags),
    .div_done  (div_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .busy      (busy)
  );

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: quot = 32'h40400000;
      {32'h41000000, 32'h40000000}: quot = 32'h40800000;
      {32'h41100000, 32'h40400000}: quot = 32'h40400000;
      {32'h3F800000, 32'h40800000}: quot = 32'h3E800000;
      {32'h3F800000, 32'h3F800000}: quot = 32'h3F800000;
      {32'h40000000, 32'h3F800000}: quot = 32'h40000000;
      {32'h3F800000, 32'h40000000}: quot = 32'h3F000000;
      default:                      quot = 32'h00000000;
    endcase
  endfunction

  assign div_out   = quot(div_op1, div_op2);
  assign div_flags = m_flg;

  always @(posedge clk) begin
    if (div_start) begin
      m_cnt    <= 0;
      div_done <= m_stale;
    end else begin
      m_cnt    <= m_cnt + 1;
      div_done <= !m_never && (m_cnt + 1 >= m_lat);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    for (int n = 0; n < 300; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept", {63'b0, ok}, 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'b0, out_valid}, 64'd1);
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int bad;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_div_start", {63'b0, div_start}, 64'd1);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_out_result", {32'b0, out_result}, 64'd0);
    chk("rst_out_flags", {58'b0, out_flags}, 64'd0);
    chk("rst_div_op1", {32'b0, div_op1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Single op: 6.0 / 2.0
    send(32'h40C00000, 32'h40000000);
    chk("run_busy", {63'b0, busy}, 64'd1);
    chk("run_div_op1", {32'b0, div_op1}, 64'h40C00000);
    chk("run_div_op2", {32'b0, div_op2}, 64'h40000000);
    n = 0;
    bad = 0;
    while (div_start === 1'b0 && n < 300) begin
      if (in_ready !== 1'b0) bad++;
      n++;
      @(posedge clk);
      #1;
    end
    chk("run_in_ready_low", 64'(bad), 64'd0);
    chk("start_low_28", 64'(n), 64'd28);
    chk("single_valid", {63'b0, out_valid}, 64'd1);
    chk("single_result", {32'b0, out_result}, 64'h40400000);
    chk("single_flags", {58'b0, out_flags}, 64'd0);
    chk("single_idle", {63'b0, busy}, 64'd0);
    pop_one();
    chk("single_one_only", {63'b0, out_valid}, 64'd0);

    // Back-pressure: FIFO fills with two results, third op blocked
    send(32'h41000000, 32'h40000000);
    send(32'h41100000, 32'h40400000);
    count_run(n);
    @(negedge clk);
    in_valid = 1'b1;
    in_op1   = 32'h3F800000;
    in_op2   = 32'h40800000;
    repeat (4) @(negedge clk);
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_busy", {63'b0, busy}, 64'd0);
    chk("bp_head1", {32'b0, out_result}, 64'h40800000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_third_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("bp_head2", {32'b0, out_result}, 64'h40400000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    wait_valid("bp_third_valid");
    chk("bp_head3", {32'b0, out_result}, 64'h3E800000);
    pop_one();
    chk("bp_empty", {63'b0, out_valid}, 64'd0);

    // Simultaneous push and pop in the capture cycle
    send(32'h3F800000, 32'h3F800000);
    wait_valid("sp_first_valid");
    send(32'h40C00000, 32'h40000000);
    n = 0;
    @(negedge clk);
    while (!(div_done && busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sp_done_seen", {63'b0, div_done}, 64'd1);
    chk("sp_head_before", {32'b0, out_result}, 64'h3F800000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sp_valid_after", {63'b0, out_valid}, 64'd1);
    chk("sp_head_after", {32'b0, out_result}, 64'h40400000);
    chk("sp_idle", {63'b0, busy}, 64'd0);
    pop_one();
    chk("sp_count1", {63'b0, out_valid}, 64'd0);

    // Stale done in first RUN cycle, flag pass-through
    m_stale = 1'b1;
    m_lat   = 5;
    m_flg   = 5'b10101;
    send(32'h40000000, 32'h3F800000);
    chk("stale_done_shown", {63'b0, div_done}, 64'd1);
    count_run(n);
    chk("stale_run_len", 64'(n), 64'd6);
    chk("stale_valid", {63'b0, out_valid}, 64'd1);
    chk("stale_result", {32'b0, out_result}, 64'h40000000);
    chk("stale_flags", {58'b0, out_flags}, 64'h15);
    m_stale = 1'b0;
    m_lat   = 27;
    m_flg   = 5'b0;

    // Reset mid-RUN with one queued result
    send(32'h3F800000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", {63'b0, div_start}, 64'd1);
    chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_ready", {63'b0, in_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(32'h3F800000, 32'h3F800000);
    wait_valid("post_rst_valid");
    chk("post_rst_result", {32'b0, out_result}, 64'h3F800000);
    chk("post_rst_flags", {58'b0, out_flags}, 64'd0);
    pop_one();
    chk("post_rst_empty", {63'b0, out_valid}, 64'd0);

`ifdef DIV_SEQ_TIMEOUT_EN
    // Divider never completes: timeout after 40 RUN cycles
    m_never = 1'b1;
    send(32'h40C00000, 32'h40000000);
    count_run(n);
    chk("to_run_len", 64'(n), 64'd40);
    chk("to_valid", {63'b0, out_valid}, 64'd1);
    chk("to_result", {32'b0, out_result}, 64'hFFC00000);
    chk("to_flags", {58'b0, out_flags}, 64'h30);
    chk("to_start", {63'b0, div_start}, 64'd1);
    m_never = 1'b0;
    pop_one();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
